// File: rtl/fir_out_capture.sv
// Output-side capture for the FIR: discard SKIP warm-up samples after an arm pulse, then
// capture a CAP_LEN-slot window into a show-ahead FIFO that the host drains via valid/ready.
module fir_out_capture #(
    parameter int DATA_W  = 12,
    parameter int DEPTH   = 16,
    parameter int SKIP    = 20,
    parameter int CAP_LEN = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam int CAP_W  = $clog2(CAP_LEN + 1);

    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP);
    localparam logic [CAP_W-1:0]  CAP_LAST  = CAP_W'(CAP_LEN);
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WARMUP, FILL, DONE} state_e;

    state_e              state_q, state_d;
    logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic [CAP_W-1:0]    cap_cnt_q, cap_cnt_d;
    logic                overflow_q, overflow_d;
    logic                busy_q, done_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                push;
    logic                pop;
    logic                full;

    assign rd_valid = (level_q != '0);
    assign full     = (level_q == FULL_LVL);
    // start discards any host pop issued in the same cycle.
    assign pop      = rd_valid && rd_ready && !start;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        overflow_d = overflow_q;
        push       = 1'b0;

        if (start) begin
            state_d    = (SKIP > 0) ? WARMUP : FILL;
            skip_cnt_d = '0;
            cap_cnt_d  = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                WARMUP: if (in_valid) begin
                    skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                    if (skip_cnt_d == SKIP_LAST) state_d = FILL;
                end
                FILL: if (in_valid) begin
                    cap_cnt_d = cap_cnt_q + CAP_W'(1);
                    if (!full || pop) push = 1'b1;
                    else              overflow_d = 1'b1;
                    if (cap_cnt_d == CAP_LAST) state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;

        if (start) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: ;
            endcase
            // The new head may be the entry being written on this very edge.
            if (level_d != '0)
                rd_data_d = (push && (wr_ptr_q == rd_ptr_d)) ? in_data : mem_q[rd_ptr_d];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            skip_cnt_q <= '0;
            cap_cnt_q  <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            overflow_q <= overflow_d;
            busy_q     <= (state_d == WARMUP) || (state_d == FILL);
            done_q     <= (state_d == DONE);
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // NOTE: the storage array has no reset; the level and pointers decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign level    = level_q;

endmodule

// File: tb/tb_fir_out_capture.sv
// Bench for fir_out_capture: three parameterisations share one stimulus stream and are
// compared every cycle against a queue-based model, plus hand-computed spot checks.
module tb_fir_out_capture;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 16;
    localparam int NI     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              rd_ready;

    logic              rv  [NI];
    logic [DATA_W-1:0] rd  [NI];
    logic              bsy [NI];
    logic              dn  [NI];
    logic              ovf [NI];
    logic [4:0]        lv  [NI];

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Instance 0: short window; 1: default window; 2: no warm-up, 4-slot window.
    int p_skip [NI] = '{20, 20, 0};
    int p_cap  [NI] = '{16, 32, 4};

    always #5 clk = ~clk;

    fir_out_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKIP(20), .CAP_LEN(16)) u_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .rd_ready(rd_ready), .rd_valid(rv[0]), .rd_data(rd[0]), .busy(bsy[0]),
        .done(dn[0]), .overflow(ovf[0]), .level(lv[0]));

    fir_out_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKIP(20), .CAP_LEN(32)) u_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .rd_ready(rd_ready), .rd_valid(rv[1]), .rd_data(rd[1]), .busy(bsy[1]),
        .done(dn[1]), .overflow(ovf[1]), .level(lv[1]));

    fir_out_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKIP(0), .CAP_LEN(4)) u_c (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .rd_ready(rd_ready), .rd_valid(rv[2]), .rd_data(rd[2]), .busy(bsy[2]),
        .done(dn[2]), .overflow(ovf[2]), .level(lv[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: count valid samples since arm; sample n (0-based) falls in the window when
    // SKIP <= n < SKIP+CAP_LEN, and the window closes after its last slot.
    logic [DATA_W-1:0] mq [NI][$];
    int                m_phase [NI];   // 0 idle, 1 armed, 2 window complete
    int                m_n     [NI];
    bit                m_ovf   [NI];
    logic [DATA_W-1:0] m_data  [NI];

    always @(posedge clk) begin
        bit popped;
        bit take;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_phase[k] = 0;
                m_n[k]     = 0;
                m_ovf[k]   = 1'b0;
                m_data[k]  = '0;
                mq[k].delete();
            end else if (start) begin
                m_phase[k] = 1;
                m_n[k]     = 0;
                m_ovf[k]   = 1'b0;
                mq[k].delete();
            end else begin
                popped = (mq[k].size() > 0) && rd_ready;
                take   = 1'b0;
                if (m_phase[k] == 1 && in_valid) begin
                    if (m_n[k] >= p_skip[k]) begin
                        if (mq[k].size() < DEPTH || popped) take = 1'b1;
                        else                                  m_ovf[k] = 1'b1;
                    end
                    m_n[k]++;
                    if (m_n[k] == p_skip[k] + p_cap[k]) m_phase[k] = 2;
                end
                if (popped) void'(mq[k].pop_front());
                if (take) mq[k].push_back(in_data);
                if (mq[k].size() > 0) m_data[k] = mq[k][0];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("u%0d rd_valid", k), 32'(rv[k]),  32'(mq[k].size() > 0));
                check($sformatf("u%0d level", k),    32'(lv[k]),  32'(mq[k].size()));
                check($sformatf("u%0d rd_data", k),  32'(rd[k]),  32'(m_data[k]));
                check($sformatf("u%0d busy", k),     32'(bsy[k]), 32'(m_phase[k] == 1));
                check($sformatf("u%0d done", k),     32'(dn[k]),  32'(m_phase[k] == 2));
                check($sformatf("u%0d overflow", k), 32'(ovf[k]), 32'(m_ovf[k]));
            end
        end
    end

    // Apply one cycle of stimulus, then return at the following falling edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic rr, input logic st);
        in_valid = v;
        in_data  = d;
        rd_ready = rr;
        start    = st;
        @(negedge clk);
    endtask

    task automatic arm();
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Idle stream without arm
        for (int i = 0; i < 10; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
        check("idle level",    32'(lv[1]),  32'd0);
        check("idle rd_valid", 32'(rv[1]),  32'd0);
        check("idle busy",     32'(bsy[1]), 32'd0);
        check("idle done",     32'(dn[0]),  32'd0);

        // Warm-up discard
        arm();
        for (int i = 0; i < 40; i++) step(1'b1, DATA_W'(100 + i), 1'b0, 1'b0);
        check("warm level",    32'(lv[0]),  32'd16);
        check("warm done",     32'(dn[0]),  32'd1);
        check("warm overflow", 32'(ovf[0]), 32'd0);
        check("nskip level",   32'(lv[2]),  32'd4);
        check("nskip head",    32'(rd[2]),  32'd100);
        for (int i = 0; i < 16; i++) begin
            check("warm drain valid", 32'(rv[0]), 32'd1);
            check("warm drain data",  32'(rd[0]), 32'(120 + i));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        check("warm drained valid", 32'(rv[0]), 32'd0);
        check("warm hold data",     32'(rd[0]), 32'd135);
        drain_all();

        // Overflow on the default window
        arm();
        for (int j = 1; j <= 52; j++) begin
            step(1'b1, DATA_W'(300 + j), 1'b0, 1'b0);
            if (j == 36) begin
                check("ovf36 level", 32'(lv[1]),  32'd16);
                check("ovf36 flag",  32'(ovf[1]), 32'd0);
            end
            if (j == 37) check("ovf37 flag", 32'(ovf[1]), 32'd1);
            if (j == 51) check("ovf51 done", 32'(dn[1]),  32'd0);
        end
        check("ovf52 done",  32'(dn[1]), 32'd1);
        check("ovf52 level", 32'(lv[1]), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("ovf drain data", 32'(rd[1]), 32'(321 + i));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        drain_all();

        // Full FIFO with simultaneous push and pop
        arm();
        for (int j = 1; j <= 36; j++) step(1'b1, DATA_W'(400 + j), 1'b0, 1'b0);
        check("fp pre level", 32'(lv[1]),  32'd16);
        check("fp pre head",  32'(rd[1]),  32'd421);
        check("fp pre busy",  32'(bsy[1]), 32'd1);
        step(1'b1, DATA_W'(999), 1'b1, 1'b0);
        check("fp level",    32'(lv[1]),  32'd16);
        check("fp overflow", 32'(ovf[1]), 32'd0);
        check("fp new head", 32'(rd[1]),  32'd422);
        for (int i = 0; i < 16; i++) begin
            check("fp drain data", 32'(rd[1]), (i < 15) ? 32'(422 + i) : 32'd999);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        drain_all();

        // Restart mid-capture
        arm();
        for (int j = 1; j <= 37; j++) step(1'b1, DATA_W'(500 + j), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("rs pre level",    32'(lv[1]),  32'd7);
        check("rs pre overflow", 32'(ovf[1]), 32'd1);
        step(1'b1, DATA_W'(77), 1'b1, 1'b1);
        check("rs level",    32'(lv[1]),  32'd0);
        check("rs rd_valid", 32'(rv[1]),  32'd0);
        check("rs overflow", 32'(ovf[1]), 32'd0);
        check("rs busy",     32'(bsy[1]), 32'd1);
        for (int j = 1; j <= 20; j++) step(1'b1, DATA_W'(600 + j), 1'b0, 1'b0);
        check("rs skip20 level", 32'(lv[1]), 32'd0);
        step(1'b1, DATA_W'(700), 1'b0, 1'b0);
        check("rs first level", 32'(lv[1]), 32'd1);
        check("rs first data",  32'(rd[1]), 32'd700);
        drain_all();

        // Signed extremes with no warm-up
        arm();
        step(1'b1, 12'h800, 1'b0, 1'b0);
        step(1'b1, 12'hFFF, 1'b0, 1'b0);
        step(1'b1, 12'h7FF, 1'b0, 1'b0);
        step(1'b1, 12'h000, 1'b0, 1'b0);
        step(1'b1, 12'h123, 1'b0, 1'b0);
        check("neg level", 32'(lv[2]), 32'd4);
        check("neg done",  32'(dn[2]), 32'd1);
        check("neg d0", 32'(rd[2]), 32'h800); step(1'b0, '0, 1'b1, 1'b0);
        check("neg d1", 32'(rd[2]), 32'hFFF); step(1'b0, '0, 1'b1, 1'b0);
        check("neg d2", 32'(rd[2]), 32'h7FF); step(1'b0, '0, 1'b1, 1'b0);
        check("neg d3", 32'(rd[2]), 32'h000); step(1'b0, '0, 1'b1, 1'b0);
        check("neg empty", 32'(rv[2]), 32'd0);

        // Reset overrides a live capture and a same-cycle start
        arm();
        for (int j = 1; j <= 3; j++) step(1'b1, DATA_W'(50 + j), 1'b0, 1'b0);
        check("rst pre level", 32'(lv[2]), 32'd3);
        rst = 1'b1;
        step(1'b1, DATA_W'(88), 1'b1, 1'b1);
        rst = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);
        check("rst level", 32'(lv[2]),  32'd0);
        check("rst data",  32'(rd[2]),  32'd0);
        check("rst busy",  32'(bsy[2]), 32'd0);
        check("rst done",  32'(dn[2]),  32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
